uart_txd_frame: RTL and testbench

Serial transmitter for the ASCII-hex frame protocol used on the board's UART link. It takes a bank byte and a 256-bit data word, encodes them as `<` + 2 bank hex chars + 64 data hex chars + `>`, and shifts them out on TXD as 8N1 characters at the same bit rate the receiving side expects. It sits opposite the frame receiver and lets the FPGA answer or echo register banks to the host.

---
 rtl/uart_txd_frame.sv | 204 ++++++++++++++++++++
 tb/tb_uart_txd_frame.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txd_frame.sv
// ASCII-hex frame transmitter: '<' + bank hex + data hex + '>' sent as 8N1 characters on TXD.
// Define UART_TXD_CRLF_EN to append CR/LF after the closing '>'.
module uart_txd_frame #(
   parameter int unsigned CLKS_PER_BIT = 54,
   parameter int unsigned NUM_BYTES    = 32
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   START,
   input  logic [7:0]             BANK,
   input  logic [8*NUM_BYTES-1:0] DATA_IN,
   output logic                   TXD,
   output logic                   BUSY,
   output logic                   DONE
);

`ifdef UART_TXD_CRLF_EN
   localparam int unsigned NumChars = 2 * NUM_BYTES + 6;
`else
   localparam int unsigned NumChars = 2 * NUM_BYTES + 4;
`endif
   localparam int unsigned    IdxW     = $clog2(NumChars);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChars - 1);
   localparam logic [7:0]     BaudLast = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStartBit,
      StDataBits,
      StStopBit,
      StNextChar
   } state_e;

   state_e                 state_q, state_d;
   logic [7:0]             baud_q, baud_d;
   logic [2:0]             bit_q, bit_d;
   logic [IdxW-1:0]        char_q, char_d;
   logic [7:0]             shift_q, shift_d;
   logic [7:0]             bank_q, bank_d;
   logic [8*NUM_BYTES-1:0] data_q, data_d;
   logic                   txd_q, txd_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [IdxW-1:0] next_idx;
   logic [7:0]      next_char;
   logic [7:0]      data_byte;
   logic [7:0]      rev_byte;
   logic [3:0]      nibble;
   int unsigned     idx;
   int unsigned     pos;
   logic            bit_end;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'h0, n};
      return 8'h57 + {4'h0, n};
   endfunction

   // Character for the slot after the current one; loaded into the shifter as its start bit begins.
   always_comb begin
      next_idx  = char_q + 1'b1;
      idx       = 32'(next_idx);
      pos       = 0;
      data_byte = '0;
      rev_byte  = '0;
      nibble    = '0;
      next_char = 8'h3E;
      if (idx == 1) begin
         next_char = hex_char(bank_q[7:4]);
      end else if (idx == 2) begin
         next_char = hex_char(bank_q[3:0]);
      end else if (idx >= 3 && idx <= 2 * NUM_BYTES + 2) begin
         pos       = idx - 3;
         data_byte = 8'(data_q >> (8 * (pos / 2)));
         // DATA_IN[8k] is the MSB of byte k so a receiver loopback reproduces DATA_IN
         for (int b = 0; b < 8; b++) rev_byte[7-b] = data_byte[b];
         nibble    = pos[0] ? rev_byte[3:0] : rev_byte[7:4];
         next_char = hex_char(nibble);
      end
`ifdef UART_TXD_CRLF_EN
      else if (idx == 2 * NUM_BYTES + 4) begin
         next_char = 8'h0D;
      end else if (idx == 2 * NUM_BYTES + 5) begin
         next_char = 8'h0A;
      end
`endif
   end

   assign bit_end = (baud_q == BaudLast);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      char_d  = char_q;
      shift_d = shift_q;
      bank_d  = bank_q;
      data_d  = data_q;
      txd_d   = txd_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (START && !busy_q) begin
               bank_d  = BANK;
               data_d  = DATA_IN;
               char_d  = '0;
               shift_d = 8'h3C;
               baud_d  = '0;
               txd_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = StStartBit;
            end
         end
         StStartBit: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               txd_d   = shift_q[0];
               state_d = StDataBits;
            end else begin
               baud_d = baud_q + 8'd1;
            end
         end
         StDataBits: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = StStopBit;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 8'd1;
            end
         end
         StStopBit: begin
            if (bit_end) begin
               baud_d = '0;
               if (char_q == LastIdx) begin
                  txd_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  char_d  = next_idx;
                  shift_d = next_char;
                  txd_d   = 1'b0;
                  state_d = StStartBit;
               end
            end else begin
               baud_d = baud_q + 8'd1;
            end
         end
         // Chaining is decided in the last stop-bit cycle, so this state only parks the FSM safely.
         StNextChar: begin
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         char_q  <= '0;
         shift_q <= '0;
         bank_q  <= '0;
         data_q  <= '0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         char_q  <= char_d;
         shift_q <= shift_d;
         bank_q  <= bank_d;
         data_q  <= data_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign TXD  = txd_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_uart_txd_frame.sv
// Scoreboard bench for uart_txd_frame: a UART-decoding monitor checks chars, DONE timing and BUSY.
// Honours UART_TXD_CRLF_EN when the design is built with it.
module tb_uart_txd_frame;

   localparam int CPB = 5;
   localparam int NB  = 4;
   localparam int DW  = 8 * NB;
`ifdef UART_TXD_CRLF_EN
   localparam int NCH = 2 * NB + 6;
`else
   localparam int NCH = 2 * NB + 4;
`endif
   localparam int F = NCH * 10 * CPB;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          START = 1'b0;
   logic [7:0]    BANK = '0;
   logic [DW-1:0] DATA_IN = '0;
   logic          TXD;
   logic          BUSY;
   logic          DONE;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;
   int last_start = 0;
   int bfrom = 0;
   int bto = -1;
   int busy_bad = 0;

   logic [7:0] exp_chars[$];
   int         done_exp[$];

   uart_txd_frame #(
      .CLKS_PER_BIT(CPB),
      .NUM_BYTES   (NB)
   ) dut (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .START  (START),
      .BANK   (BANK),
      .DATA_IN(DATA_IN),
      .TXD    (TXD),
      .BUSY   (BUSY),
      .DONE   (DONE)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW; i++) d[i] = 1'($urandom_range(0, 1));
      return d;
   endfunction

   // Reference model: the frame as the list of characters a receiver should see.
   task automatic push_frame(input logic [7:0] b, input logic [DW-1:0] d);
      string hx;
      int    v;
      hx = "0123456789abcdef";
      exp_chars.push_back(8'h3C);
      exp_chars.push_back(8'(hx[b / 16]));
      exp_chars.push_back(8'(hx[b % 16]));
      for (int k = 0; k < NB; k++) begin
         v = 0;
         for (int j = 0; j < 8; j++) v = v * 2 + (d[8*k+j] ? 1 : 0);
         exp_chars.push_back(8'(hx[v / 16]));
         exp_chars.push_back(8'(hx[v % 16]));
      end
      exp_chars.push_back(8'h3E);
`ifdef UART_TXD_CRLF_EN
      exp_chars.push_back(8'h0D);
      exp_chars.push_back(8'h0A);
`endif
   endtask

   // Call at a negedge: the START is sampled on the next posedge (that cycle is "cycle 0").
   task automatic start_frame(input logic [7:0] b, input logic [DW-1:0] d);
      last_start = cyc;
      START   = 1'b1;
      BANK    = b;
      DATA_IN = d;
      push_frame(b, d);
      done_exp.push_back(cyc + F + 1);
      bfrom = cyc + 1;
      bto   = cyc + F;
      @(posedge CLK);
      #1;
      START   = 1'b0;
      BANK    = 8'($urandom);
      DATA_IN = rand_data();
   endtask

   // Returns at the negedge where DONE is seen; optionally pokes START mid-frame.
   task automatic wait_done(input bit poke);
      bit found;
      found = 1'b0;
      for (int n = 0; n < F + 20; n++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin
            found = 1'b1;
            break;
         end
         if (poke && (n == F / 3 || n == (2 * F) / 3)) begin
            START   = 1'b1;
            BANK    = 8'($urandom);
            DATA_IN = rand_data();
            @(posedge CLK);
            #1;
            START = 1'b0;
         end
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: no DONE within %0d cycles (cycle %0d)", F + 20, cyc);
      end
   endtask

   // Monitor: UART receiver sampling mid-bit, plus DONE/BUSY scoreboard.
   initial begin
      int         mstate;
      int         moff;
      int         bi;
      logic [9:0] mbits;
      logic [7:0] e;
      mstate = 0;
      moff   = 0;
      mbits  = '0;
      forever begin
         @(negedge CLK);
         if (!RST_N) begin
            mstate   = 0;
            busy_bad = 0;
         end else begin
            if (BUSY !== ((cyc >= bfrom && cyc <= bto) ? 1'b1 : 1'b0)) busy_bad++;
            if (DONE === 1'b1) begin
               if (done_exp.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL done_unexpected: DONE high with no frame pending (cycle %0d)", cyc);
               end else begin
                  check("done_cycle", 64'(cyc), 64'(done_exp.pop_front()));
               end
               check("busy_window_errors", 64'(busy_bad), 64'd0);
               busy_bad = 0;
            end
            if (mstate == 0) begin
               if (TXD === 1'b0) begin
                  mstate = 1;
                  moff   = 0;
               end
            end else begin
               moff++;
               if (moff % CPB == CPB / 2) begin
                  bi        = moff / CPB;
                  mbits[bi] = TXD;
                  if (bi == 9) begin
                     mstate = 0;
                     if (exp_chars.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL char_unexpected: got 'h%0h with none expected", mbits[8:1]);
                     end else begin
                        e = exp_chars.pop_front();
                        check("char", 64'(mbits), 64'({1'b1, e, 1'b0}));
                     end
                  end
               end
            end
         end
      end
   end

   initial begin
      int         bad;
      int         bi;
      logic [7:0] c0;
      logic       ev;

      repeat (3) @(negedge CLK);
      check("reset_txd", 64'(TXD), 64'd1);
      check("reset_busy", 64'(BUSY), 64'd0);
      check("reset_done", 64'(DONE), 64'd0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Bank 0x05, zero data, with exact waveform of the first char '<'.
      start_frame(8'h05, '0);
      c0  = 8'h3C;
      bad = 0;
      for (int t = 1; t <= 10 * CPB; t++) begin
         @(negedge CLK);
         bi = (t - 1) / CPB;
         ev = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : c0[bi-1];
         if (TXD !== ev) bad++;
      end
      check("first_char_wave_errors", 64'(bad), 64'd0);
      wait_done(1'b0);

      // START in the DONE cycle; extra STARTs mid-frame must be ignored.
      start_frame(8'hAB, DW'(1));
      wait_done(1'b1);

      // Reset mid-frame aborts at once; a following frame is complete.
      repeat (3) @(negedge CLK);
      start_frame(8'($urandom), rand_data());
      repeat (F / 2) @(negedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check("abort_txd", 64'(TXD), 64'd1);
      check("abort_busy", 64'(BUSY), 64'd0);
      check("abort_done", 64'(DONE), 64'd0);
      exp_chars.delete();
      done_exp.delete();
      bto = -1;
      repeat (3) @(negedge CLK);
      check("abort_hold_txd", 64'(TXD), 64'd1);
      RST_N = 1'b1;
      @(negedge CLK);
      start_frame(8'($urandom), rand_data());
      wait_done(1'b0);

      // Random frames with random gaps (gap 0 = START in the DONE cycle).
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 3)) @(negedge CLK);
         start_frame(8'($urandom), rand_data());
         wait_done(1'($urandom_range(0, 1)));
      end

      repeat (2 * CPB) @(negedge CLK);
      check("chars_left", 64'(exp_chars.size()), 64'd0);
      check("dones_left", 64'(done_exp.size()), 64'd0);
      check("idle_txd", 64'(TXD), 64'd1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
